// File: rtl/uart_fifo_pkg.sv
// Shared constants for the UART transmit FIFO and the transmitter that drains it.
package uart_fifo_pkg;

    localparam int   DEF_DATA_W  = 8;
    localparam int   DEF_DEPTH   = 16;
    localparam logic READ_ACTIVE = 1'b0;

    function automatic int addr_width(input int depth);
        int w;
        w = 0;
        while ((1 << w) < depth) w++;
        return w;
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x DATA_W simple dual-port storage with a registered read port.
// The read register doubles as the byte presented to the transmitter.
module uart_fifo_ram
    import uart_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = addr_width(DEF_DEPTH)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Old contents are returned when read and write hit the same slot (full FIFO).
    always_ff @(posedge clk) begin
        if (clr)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding the UART transmitter; active-low pop strobe, sticky error flags.
// Define UART_TX_FIFO_AFULL_EN to build the registered almost-full flag.
module uart_tx_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int ADDR_W      = addr_width(DEPTH),
    parameter int AFULL_LEVEL = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              fifo_read_tx,
    output logic [DATA_W-1:0] tx_dout_reg,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err,
    output logic              fifo_afull
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    if ((1 << ADDR_W) != DEPTH || DEPTH < 2 || DEPTH > 256) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of two in 2..256 matching ADDR_W");
    end
    if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
        $error("uart_tx_fifo: AFULL_LEVEL must lie in 1..DEPTH");
    end

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count, count_next;
    logic              rd_req, rd_ok, wr_ok;
    logic              ovf_set, udf_set;

    assign rd_req  = (fifo_read_tx == READ_ACTIVE);
    assign rd_ok   = rd_req && (count != '0) && !flush;
    assign wr_ok   = wr_en && ((count != DEPTH_C) || rd_ok) && !flush;
    assign ovf_set = wr_en && !wr_ok && !flush;
    assign udf_set = rd_req && (count == '0) && !flush;

    always_comb begin
        count_next = count;
        if (flush)               count_next = '0;
        else if (wr_ok && !rd_ok) count_next = count + 1'b1;
        else if (rd_ok && !wr_ok) count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
                if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            end
            count      <= count_next;
            fifo_empty <= (count_next == '0);
            fifo_full  <= (count_next == DEPTH_C);
            // A fresh error in the clearing cycle keeps its flag set.
            overflow   <= ovf_set | (overflow & ~clr_err);
            underflow  <= udf_set | (underflow & ~clr_err);
        end
    end

    assign fifo_count = count;

`ifdef UART_TX_FIFO_AFULL_EN
    localparam logic [ADDR_W:0] AFULL_C = (ADDR_W+1)'(AFULL_LEVEL);
    logic afull_q;

    always_ff @(posedge clk) begin
        if (reset) afull_q <= 1'b0;
        else       afull_q <= (count_next >= AFULL_C);
    end

    assign fifo_afull = afull_q;
`else
    assign fifo_afull = 1'b0;
`endif

    uart_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .clr     (reset | flush),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (tx_dout_reg)
    );

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scenario bench for uart_tx_fifo: queue model of accepted bytes, compared on each pop.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       fifo_read_tx = 1'b1;
    logic       clr_err = 1'b0;
    logic [7:0] tx_dout_reg;
    logic       fifo_empty, fifo_full, overflow, underflow, fifo_afull;
    logic [4:0] fifo_count;

    int total = 0;
    int bad = 0;
    logic [7:0] q[$];
    logic [7:0] exp_b;
    logic [7:0] last_b;

    uart_tx_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .fifo_read_tx (fifo_read_tx),
        .tx_dout_reg  (tx_dout_reg),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err),
        .fifo_afull   (fifo_afull)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        wr_en = 1'b1;
        wr_data = d;
        if (q.size() < 16) q.push_back(d);
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic rd_strobe();
        fifo_read_tx = 1'b0;
        cyc();
        fifo_read_tx = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        total++;
        if (fifo_count !== 5'd0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0 || tx_dout_reg !== 8'h00 ||
            overflow !== 1'b0 || underflow !== 1'b0 || fifo_afull !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got cnt=%0d e=%b f=%b d=%h o=%b u=%b a=%b exp cnt=0 e=1 f=0 d=00 o=0 u=0 a=0",
                     fifo_count, fifo_empty, fifo_full, tx_dout_reg, overflow, underflow, fifo_afull);
        end
    endtask

    task automatic test_basic();
        wr(8'h41); wr(8'h42); wr(8'h43);
        total++;
        if (fifo_count !== 5'd3 || fifo_empty !== 1'b0) begin
            bad++;
            $display("FAIL basic_load got cnt=%0d e=%b exp cnt=3 e=0", fifo_count, fifo_empty);
        end
        for (int i = 0; i < 3; i++) begin
            exp_b = q.pop_front();
            rd_strobe();
            total++;
            if (tx_dout_reg !== exp_b) begin
                bad++;
                $display("FAIL basic_data%0d got=%h exp=%h", i, tx_dout_reg, exp_b);
            end
            cyc(); cyc(); cyc();
            total++;
            if (tx_dout_reg !== exp_b) begin
                bad++;
                $display("FAIL basic_hold%0d got=%h exp=%h", i, tx_dout_reg, exp_b);
            end
        end
        total++;
        if (fifo_empty !== 1'b1 || fifo_count !== 5'd0) begin
            bad++;
            $display("FAIL basic_empty got e=%b cnt=%0d exp e=1 cnt=0", fifo_empty, fifo_count);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) begin
            wr(8'(i));
            if (i == 14) begin
                total++;
                if (fifo_full !== 1'b0) begin
                    bad++;
                    $display("FAIL ovf_not_full15 got=%b exp=0", fifo_full);
                end
            end
        end
        total++;
        if (fifo_full !== 1'b1 || fifo_count !== 5'd16) begin
            bad++;
            $display("FAIL ovf_full got f=%b cnt=%0d exp f=1 cnt=16", fifo_full, fifo_count);
        end
        wr(8'hAA);
        total++;
        if (overflow !== 1'b1 || fifo_count !== 5'd16) begin
            bad++;
            $display("FAIL ovf_drop got o=%b cnt=%0d exp o=1 cnt=16", overflow, fifo_count);
        end
        for (int i = 0; i < 16; i++) begin
            exp_b = q.pop_front();
            rd_strobe();
            total++;
            if (tx_dout_reg !== exp_b) begin
                bad++;
                $display("FAIL ovf_drain%0d got=%h exp=%h", i, tx_dout_reg, exp_b);
            end
        end
        total++;
        if (fifo_empty !== 1'b1 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_after_drain got e=%b o=%b exp e=1 o=1", fifo_empty, overflow);
        end
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear got=%b exp=0", overflow);
        end
    endtask

    task automatic test_simul_full();
        for (int i = 0; i < 16; i++) wr(8'(i));
        wr_en = 1'b1;
        wr_data = 8'h55;
        fifo_read_tx = 1'b0;
        exp_b = q.pop_front();
        q.push_back(8'h55);
        cyc();
        wr_en = 1'b0;
        fifo_read_tx = 1'b1;
        total++;
        if (fifo_count !== 5'd16 || tx_dout_reg !== exp_b || overflow !== 1'b0 || fifo_full !== 1'b1) begin
            bad++;
            $display("FAIL simul_full got cnt=%0d d=%h o=%b f=%b exp cnt=16 d=%h o=0 f=1",
                     fifo_count, tx_dout_reg, overflow, fifo_full, exp_b);
        end
        for (int i = 0; i < 16; i++) begin
            exp_b = q.pop_front();
            rd_strobe();
            total++;
            if (tx_dout_reg !== exp_b) begin
                bad++;
                $display("FAIL simul_drain%0d got=%h exp=%h", i, tx_dout_reg, exp_b);
            end
        end
        last_b = exp_b;
        total++;
        if (fifo_empty !== 1'b1 || tx_dout_reg !== 8'h55) begin
            bad++;
            $display("FAIL simul_last got e=%b d=%h exp e=1 d=55", fifo_empty, tx_dout_reg);
        end
    endtask

    task automatic test_underflow();
        rd_strobe();
        total++;
        if (underflow !== 1'b1 || tx_dout_reg !== last_b) begin
            bad++;
            $display("FAIL udf_set got u=%b d=%h exp u=1 d=%h", underflow, tx_dout_reg, last_b);
        end
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        total++;
        if (underflow !== 1'b0) begin
            bad++;
            $display("FAIL udf_clear got=%b exp=0", underflow);
        end
        clr_err = 1'b1;
        fifo_read_tx = 1'b0;
        cyc();
        clr_err = 1'b0;
        fifo_read_tx = 1'b1;
        total++;
        if (underflow !== 1'b1) begin
            bad++;
            $display("FAIL udf_clr_race got=%b exp=1", underflow);
        end
    endtask

    task automatic test_back_to_back();
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        wr(8'h3C);
        exp_b = q.pop_front();
        fifo_read_tx = 1'b0;
        cyc();
        total++;
        if (tx_dout_reg !== exp_b || fifo_empty !== 1'b1 || underflow !== 1'b0) begin
            bad++;
            $display("FAIL b2b_first got d=%h e=%b u=%b exp d=%h e=1 u=0", tx_dout_reg, fifo_empty, underflow, exp_b);
        end
        cyc();
        fifo_read_tx = 1'b1;
        total++;
        if (tx_dout_reg !== exp_b || underflow !== 1'b1 || fifo_count !== 5'd0) begin
            bad++;
            $display("FAIL b2b_second got d=%h u=%b cnt=%0d exp d=%h u=1 cnt=0", tx_dout_reg, underflow, fifo_count, exp_b);
        end
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 5; i++) wr(8'h60 + 8'(i));
        for (int i = 0; i < 2; i++) begin
            exp_b = q.pop_front();
            rd_strobe();
            total++;
            if (tx_dout_reg !== exp_b) begin
                bad++;
                $display("FAIL flush_pre%0d got=%h exp=%h", i, tx_dout_reg, exp_b);
            end
        end
        flush = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'hEE;
        fifo_read_tx = 1'b0;
        cyc();
        flush = 1'b0;
        wr_en = 1'b0;
        fifo_read_tx = 1'b1;
        q.delete();
        total++;
        if (fifo_count !== 5'd0 || fifo_empty !== 1'b1 || tx_dout_reg !== 8'h00 ||
            underflow !== 1'b1 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL flush_state got cnt=%0d e=%b d=%h u=%b o=%b exp cnt=0 e=1 d=00 u=1 o=0",
                     fifo_count, fifo_empty, tx_dout_reg, underflow, overflow);
        end
        wr(8'h77);
        exp_b = q.pop_front();
        rd_strobe();
        total++;
        if (tx_dout_reg !== exp_b) begin
            bad++;
            $display("FAIL flush_post got=%h exp=%h", tx_dout_reg, exp_b);
        end
        wr(8'h12);
        reset = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'h99;
        cyc();
        reset = 1'b0;
        wr_en = 1'b0;
        q.delete();
        total++;
        if (fifo_count !== 5'd0 || fifo_empty !== 1'b1 || tx_dout_reg !== 8'h00 || underflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_wins got cnt=%0d e=%b d=%h u=%b exp cnt=0 e=1 d=00 u=0",
                     fifo_count, fifo_empty, tx_dout_reg, underflow);
        end
    endtask

    task automatic test_afull();
        for (int i = 0; i < 11; i++) wr(8'h80 + 8'(i));
        total++;
        if (fifo_afull !== 1'b0 || fifo_count !== 5'd11) begin
            bad++;
            $display("FAIL afull_11 got a=%b cnt=%0d exp a=0 cnt=11", fifo_afull, fifo_count);
        end
        wr(8'h8B);
`ifdef UART_TX_FIFO_AFULL_EN
        total++;
        if (fifo_afull !== 1'b1) begin
            bad++;
            $display("FAIL afull_12 got=%b exp=1", fifo_afull);
        end
`else
        total++;
        if (fifo_afull !== 1'b0) begin
            bad++;
            $display("FAIL afull_12_off got=%b exp=0", fifo_afull);
        end
`endif
        exp_b = q.pop_front();
        rd_strobe();
        total++;
        if (fifo_afull !== 1'b0 || tx_dout_reg !== exp_b) begin
            bad++;
            $display("FAIL afull_read got a=%b d=%h exp a=0 d=%h", fifo_afull, tx_dout_reg, exp_b);
        end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_simul_full();
        test_underflow();
        test_back_to_back();
        test_flush_reset();
        test_afull();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
